// File: rtl/noc_target_adapter.sv
// NoC target adapter: turns request flits into sync-SRAM accesses and read responses.
// Optional destination filtering is enabled by defining NOC_TARGET_DEST_FILTER_EN.
module noc_target_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int NODE_ID    = 0,
  parameter int LOCAL_AW   = DATA_WIDTH - 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_dest,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [LOCAL_AW-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WR_COMMIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_RESP,
    S_DROP
  } state_t;

  localparam logic [7:0] LP_NODE = 8'(NODE_ID);

  state_t r_state;
  state_t w_next;

  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [LOCAL_AW-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [7:0]            r_tx_dest;

  logic                  w_rx_fire;
  logic [7:0]            w_hdr_dest;
  logic [7:0]            w_hdr_src;
  logic                  w_hdr_rw;
  logic [LOCAL_AW-1:0]   w_hdr_addr;
  logic                  w_hdr_ok;
  logic                  w_unused;

  assign w_hdr_dest = rx_data[DATA_WIDTH-1 -: 8];
  assign w_hdr_src  = rx_data[DATA_WIDTH-12 -: 8];
  assign w_hdr_rw   = rx_data[DATA_WIDTH-20];
  assign w_hdr_addr = rx_data[LOCAL_AW-1:0];
  assign w_unused   = ^{rx_data, w_hdr_dest};

`ifdef NOC_TARGET_DEST_FILTER_EN
  logic [15:0] r_drop_count;

  assign w_hdr_ok   = (w_hdr_dest == LP_NODE);
  assign drop_count = r_drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else if (r_state == S_IDLE && w_rx_fire && !w_hdr_ok
                 && r_drop_count != 16'hFFFF) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end
`else
  assign w_hdr_ok   = 1'b1;
  assign drop_count = '0;
`endif

  assign rx_ready  = rst_n & ((r_state == S_IDLE) |
                              (r_state == S_WDATA) |
                              (r_state == S_DROP));
  assign w_rx_fire = rx_valid & rx_ready;
  assign tx_valid  = (r_state == S_RESP);
  assign tx_data   = r_tx_data;
  assign tx_dest   = r_tx_dest;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          if (!w_hdr_ok) begin
            w_next = w_hdr_rw ? S_DROP : S_IDLE;
          end else begin
            w_next = w_hdr_rw ? S_WDATA : S_RD_REQ;
          end
        end
      end
      S_WDATA:     if (w_rx_fire) w_next = S_WR_COMMIT;
      S_WR_COMMIT: w_next = S_IDLE;
      S_RD_REQ:    w_next = S_RD_WAIT;
      S_RD_WAIT:   w_next = S_RESP;
      S_RESP:      if (tx_ready) w_next = S_IDLE;
      S_DROP:      if (w_rx_fire) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Strobes are one-cycle pulses launched from the accepting handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tx_data   <= '0;
      r_tx_dest   <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      if (r_state == S_IDLE && w_rx_fire && w_hdr_ok) begin
        r_mem_addr <= w_hdr_addr;
        r_tx_dest  <= w_hdr_src;
        if (!w_hdr_rw) r_mem_en <= 1'b1;
      end
      if (r_state == S_WDATA && w_rx_fire) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_wdata <= rx_data;
      end
      if (r_state == S_RD_WAIT) r_tx_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_noc_target_adapter.sv
// Randomized bench for noc_target_adapter with a transaction-level timing model.
module tb_noc_target_adapter;

  logic        clk;
  logic        rst_n;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_dest;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] drop_count;

  noc_target_adapter #(.DATA_WIDTH(32), .NODE_ID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dest(tx_dest),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .drop_count(drop_count)
  );

`ifdef NOC_TARGET_DEST_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return (a == 12'h0A4) ? 32'h12345678 : {20'hA5C3E, a};
  endfunction

  function automatic logic [31:0] hdr(input logic [7:0] d, input logic [7:0] s,
                                      input logic rw, input logic [11:0] a);
    return {d, 3'd3, s, rw, a};
  endfunction

  // SRAM seen by the DUT
  logic [31:0] sram [logic [11:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] = mem_wdata;
      else mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : init_val(mem_addr);
    end
  end

  // Reference model: events scheduled by cycle number
  typedef struct {
    int          c;
    bit          we;
    logic [11:0] a;
    logic [31:0] d;
  } strobe_t;

  strobe_t     sq[$];
  logic [31:0] ref_mem [logic [11:0]];
  bit          m_wait_data, m_drop_data, m_resp;
  int          m_block_end, m_resp_start;
  logic [11:0] m_addr;
  logic [7:0]  m_src;
  logic [31:0] m_tx_data;
  logic [7:0]  m_tx_dest;
  logic [15:0] m_drops;

  // Observations for directed literal checks
  int          obs_wr_cnt = 0, obs_en_cnt = 0, obs_resp_cnt = 0, obs_rise = 0;
  logic [11:0] obs_wr_addr;
  logic [31:0] obs_wr_data, obs_resp_data;
  logic [7:0]  obs_resp_dest;
  bit          obs_we_q[$];
  bit          prev_txv = 0;

  always @(negedge clk) begin
    bit exp_ready, exp_txv, exp_en;
    logic [31:0] v;
    if (!rst_n) begin
      chk("rst_rx_ready", 32'(rx_ready), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_dest", 32'(tx_dest), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_drop_count", 32'(drop_count), 0);
      m_wait_data = 0; m_drop_data = 0; m_resp = 0;
      m_block_end = 0; m_drops = 0; prev_txv = 0;
      sq.delete();
    end else begin
      exp_ready = !m_resp && cyc >= m_block_end;
      exp_txv   = m_resp && cyc >= m_resp_start;
      exp_en    = sq.size() > 0 && sq[0].c == cyc;
      chk("rx_ready", 32'(rx_ready), 32'(exp_ready));
      chk("tx_valid", 32'(tx_valid), 32'(exp_txv));
      chk("mem_en", 32'(mem_en), 32'(exp_en));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      if (exp_en) begin
        strobe_t s;
        s = sq.pop_front();
        chk("mem_we", 32'(mem_we), 32'(s.we));
        chk("mem_addr", 32'(mem_addr), 32'(s.a));
        if (s.we) begin
          chk("mem_wdata", mem_wdata, s.d);
          ref_mem[s.a] = s.d;
        end else begin
          m_tx_data = ref_mem.exists(s.a) ? ref_mem[s.a] : init_val(s.a);
        end
      end else begin
        chk("mem_we_idle", 32'(mem_we), 0);
      end
      if (exp_txv) begin
        chk("tx_data", tx_data, m_tx_data);
        chk("tx_dest", 32'(tx_dest), 32'(m_tx_dest));
      end
      // observations of the DUT itself
      if (mem_en) begin
        obs_en_cnt++;
        obs_we_q.push_back(mem_we);
      end
      if (mem_en && mem_we) begin
        obs_wr_cnt++; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata;
      end
      if (tx_valid && !prev_txv) obs_rise = cyc;
      if (tx_valid && tx_ready) begin
        obs_resp_cnt++; obs_resp_data = tx_data; obs_resp_dest = tx_dest;
      end
      prev_txv = tx_valid;
      // advance the model across the coming edge
      if (exp_txv && tx_ready) begin
        m_resp = 0; m_block_end = cyc + 1;
      end
      if (rx_valid && exp_ready) begin
        v = rx_data;
        if (m_wait_data) begin
          sq.push_back('{cyc + 1, 1'b1, m_addr, v});
          m_wait_data = 0; m_block_end = cyc + 2;
        end else if (m_drop_data) begin
          m_drop_data = 0;
        end else if (FILT && v[31:24] != 8'd0) begin
          if (m_drops != 16'hFFFF) m_drops++;
          if (v[12]) m_drop_data = 1;
        end else begin
          m_addr = v[11:0]; m_src = v[20:13];
          if (v[12]) m_wait_data = 1;
          else begin
            sq.push_back('{cyc + 1, 1'b0, v[11:0], 32'd0});
            m_resp = 1; m_resp_start = cyc + 3; m_tx_dest = v[20:13];
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, output int hs);
    int n = 0;
    bit acc = 0;
    hs = -1;
    rx_valid = 1'b1; rx_data = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rx_ready;
      if (acc) hs = cyc;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    chk("send_accepted", 32'(acc), 1);
  endtask

  task automatic wait_resp();
    int start = obs_resp_cnt;
    int n = 0;
    while (obs_resp_cnt == start && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("resp_seen", 32'(obs_resp_cnt != start), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hs, w0, e0, r0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // read: data preloaded at 0x0A4
    tx_ready = 1'b1;
    send(32'h0060_A0A4, hs);
    wait_resp();
    chk("rd_data", obs_resp_data, 32'h12345678);
    chk("rd_dest", 32'(obs_resp_dest), 32'h05);
    chk("rd_latency", 32'(obs_rise - hs), 3);
    idle(2);

    // write
    w0 = obs_wr_cnt; r0 = obs_resp_cnt;
    send(32'h0060_B0A4, hs);
    send(32'hDEADBEEF, hs);
    idle(4);
    chk("wr_strobe_cycles", 32'(obs_wr_cnt - w0), 1);
    chk("wr_addr", 32'(obs_wr_addr), 32'h0A4);
    chk("wr_data", obs_wr_data, 32'hDEADBEEF);
    chk("wr_no_resp", 32'(obs_resp_cnt - r0), 0);

    // backpressure in RESP
    tx_ready = 1'b0;
    send(32'h0060_A0A4, hs);
    idle(3);
    repeat (5) begin
      @(negedge clk);
      chk("bp_tx_valid", 32'(tx_valid), 1);
      chk("bp_rx_ready", 32'(rx_ready), 0);
      chk("bp_tx_data", tx_data, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_resp();
    chk("bp_data", obs_resp_data, 32'hDEADBEEF);
    idle(2);

    // write to foreign dest, then local read
    w0 = obs_wr_cnt;
    send(hdr(8'h07, 8'h09, 1'b1, 12'h0A4), hs);
    send(32'hCAFEF00D, hs);
    idle(3);
    chk("flt_drop_count", 32'(drop_count), FILT ? 32'd1 : 32'd0);
    chk("flt_wr_strobes", 32'(obs_wr_cnt - w0), FILT ? 32'd0 : 32'd1);
    send(32'h0060_A0A4, hs);
    wait_resp();
    chk("flt_rd_data", obs_resp_data, FILT ? 32'hDEADBEEF : 32'hCAFEF00D);
    idle(2);

    // reset while in RD_WAIT
    r0 = obs_resp_cnt;
    send(hdr(8'h00, 8'h11, 1'b0, 12'h003), hs);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_mem_en", 32'(mem_en), 0);
    idle(2);
    rst_n = 1'b1;
    e0 = obs_en_cnt;
    idle(10);
    chk("post_rst_no_strobe", 32'(obs_en_cnt - e0), 0);
    chk("post_rst_no_resp", 32'(obs_resp_cnt - r0), 0);
    send(hdr(8'h00, 8'h12, 1'b0, 12'h004), hs);
    chk("post_rst_hdr_hs", 32'(hs >= 0), 1);
    wait_resp();
    chk("post_rst_data", obs_resp_data, init_val(12'h004));
    idle(2);

    // back-to-back read, write, read
    obs_we_q.delete();
    send(hdr(8'h00, 8'h01, 1'b0, 12'h005), hs);
    send(hdr(8'h00, 8'h02, 1'b1, 12'h005), hs);
    send(32'h0BADF00D, hs);
    send(hdr(8'h00, 8'h03, 1'b0, 12'h005), hs);
    wait_resp();
    chk("b2b_count", 32'(obs_we_q.size()), 3);
    if (obs_we_q.size() == 3) begin
      chk("b2b_first_rd", 32'(obs_we_q[0]), 0);
      chk("b2b_wr", 32'(obs_we_q[1]), 1);
      chk("b2b_second_rd", 32'(obs_we_q[2]), 0);
    end
    chk("b2b_rd_after_wr", obs_resp_data, 32'h0BADF00D);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = {($urandom_range(0, 3) == 0) ? 8'h07 : 8'h00,
                  3'($urandom), 8'($urandom), 1'($urandom),
                  12'($urandom_range(0, 15))};
      tx_ready = ($urandom_range(0, 9) < 7);
      idle(1);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
